// File: rtl/seq_extremum_pkg.sv
// Shared types and constants for the sequential extremum finder.
//   state_e  : controller states (idle, scanning operands, publishing result)
//   MODE_MAX : mode_min value that selects a maximum search
//   MODE_MIN : mode_min value that selects a minimum search
package seq_extremum_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScan   = 2'd1,
        StFinish = 2'd2
    } state_e;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/seq_extremum_finder_if.sv
// Job bus between a controller and the extremum finder.
//   start, mode_min, is_signed, operands : job request (controller -> finder)
//   busy, result, result_idx, done       : job status and answer (finder -> controller)
// master = controller side, slave = finder side.
interface seq_extremum_finder_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8
);
    localparam int unsigned IDX_W = $clog2(N);

    logic               start;
    logic               mode_min;
    logic               is_signed;
    logic [N*WIDTH-1:0] operands;
    logic               busy;
    logic [WIDTH-1:0]   result;
    logic [IDX_W-1:0]   result_idx;
    logic               done;

    modport master (
        output start, mode_min, is_signed, operands,
        input  busy, result, result_idx, done
    );

    modport slave (
        input  start, mode_min, is_signed, operands,
        output busy, result, result_idx, done
    );

endinterface

// File: rtl/extremum_cmp.sv
// Combinational "strictly better" test for the extremum scan.
//   a, b      : candidate and current best
//   mode_min  : MODE_MIN -> a better when a < b; MODE_MAX -> a better when a > b
//   is_signed : compare as two's complement when set
//   a_better  : a strictly beats b (equality never wins, so ties keep the earlier index)
module extremum_cmp
    import seq_extremum_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode_min,
    input  logic             is_signed,
    output logic             a_better
);
    logic a_gt_b;
    logic a_lt_b;

    always_comb begin
        if (is_signed) begin
            a_gt_b = $signed(a) > $signed(b);
            a_lt_b = $signed(a) < $signed(b);
        end else begin
            a_gt_b = a > b;
            a_lt_b = a < b;
        end
        a_better = (mode_min == MODE_MIN) ? a_lt_b : a_gt_b;
    end

endmodule

// File: rtl/seq_extremum_finder.sv
// Sequential max/min reduction over N operands, one comparison per cycle.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of the job bus (start/mode/operands in, busy/result/done out)
// A job accepted at edge t publishes result/result_idx with done after edge t+N.
module seq_extremum_finder
    import seq_extremum_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_extremum_finder_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(N);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ops_q [N];
    logic [WIDTH-1:0] ops_d [N];
    logic             mode_min_q, mode_min_d;
    logic             is_signed_q, is_signed_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] result_idx_q, result_idx_d;

    logic [WIDTH-1:0] cur_op;
    logic             cur_better;

    assign cur_op = ops_q[i_q];

    extremum_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a         (cur_op),
        .b         (best_q),
        .mode_min  (mode_min_q),
        .is_signed (is_signed_q),
        .a_better  (cur_better)
    );

    always_comb begin
        state_d      = state_q;
        ops_d        = ops_q;
        mode_min_d   = mode_min_q;
        is_signed_d  = is_signed_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        i_d          = i_q;
        busy_d       = busy_q;
        done_d       = done_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    for (int k = 0; k < int'(N); k++) begin
                        ops_d[k] = bus.operands[k*WIDTH +: WIDTH];
                    end
                    mode_min_d  = bus.mode_min;
                    is_signed_d = bus.is_signed;
                    // op[0] seeds the best so the scan starts at index 1
                    best_d      = bus.operands[WIDTH-1:0];
                    best_idx_d  = '0;
                    i_d         = IDX_W'(1);
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = StScan;
                end
            end
            StScan: begin
                if (cur_better) begin
                    best_d     = cur_op;
                    best_idx_d = i_q;
                end
                if (i_q == IDX_W'(N - 1)) begin
                    state_d = StFinish;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            StFinish: begin
                result_d     = best_q;
                result_idx_d = best_idx_q;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            for (int k = 0; k < int'(N); k++) begin
                ops_q[k] <= '0;
            end
            mode_min_q   <= 1'b0;
            is_signed_q  <= 1'b0;
            best_q       <= '0;
            best_idx_q   <= '0;
            i_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            result_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            ops_q        <= ops_d;
            mode_min_q   <= mode_min_d;
            is_signed_q  <= is_signed_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            i_q          <= i_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.result_idx = result_idx_q;

endmodule

// File: tb/tb_seq_extremum_finder.sv
// Directed bench: a 32-bit/4-operand finder and an 8-bit/2-operand finder on one clock.
module tb_seq_extremum_finder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_extremum_finder_if #(.WIDTH(32), .N(4)) bus_a ();
    seq_extremum_finder_if #(.WIDTH(8),  .N(2)) bus_b ();

    seq_extremum_finder #(.WIDTH(32), .N(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seq_extremum_finder #(.WIDTH(8), .N(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [127:0] OPS_T1 = {32'd9, 32'd3, 32'd9, 32'd5};
    localparam logic [127:0] OPS_T2 = {32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    localparam logic [127:0] OPS_JUNK = {4{32'd100}};
    localparam logic [15:0]  OPS_T6 = {8'h7F, 8'h80};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start on the N=4 finder; checks busy for exactly 4 cycles, then the answer.
    task automatic job_a(input logic [127:0] ops, input logic mm, input logic sg,
                         input logic [31:0] exp_res, input logic [1:0] exp_idx, input string tag);
        @(negedge clk);
        bus_a.operands  = ops;
        bus_a.mode_min  = mm;
        bus_a.is_signed = sg;
        bus_a.start     = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk({tag, ".busy0"}, 64'(bus_a.busy), 64'd1);
        chk({tag, ".done0"}, 64'(bus_a.done), 64'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk({tag, ".busy"}, 64'(bus_a.busy), 64'd1);
            chk({tag, ".done_early"}, 64'(bus_a.done), 64'd0);
        end
        @(negedge clk);
        chk({tag, ".done"}, 64'(bus_a.done), 64'd1);
        chk({tag, ".busy_end"}, 64'(bus_a.busy), 64'd0);
        chk({tag, ".result"}, 64'(bus_a.result), 64'(exp_res));
        chk({tag, ".idx"}, 64'(bus_a.result_idx), 64'(exp_idx));
    endtask

    // One-cycle start on the N=2 finder; done expected 2 edges after accept.
    task automatic job_b(input logic [15:0] ops, input logic sg,
                         input logic [7:0] exp_res, input logic exp_idx, input string tag);
        @(negedge clk);
        bus_b.operands  = ops;
        bus_b.mode_min  = 1'b0;
        bus_b.is_signed = sg;
        bus_b.start     = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        chk({tag, ".busy0"}, 64'(bus_b.busy), 64'd1);
        @(negedge clk);
        chk({tag, ".busy1"}, 64'(bus_b.busy), 64'd1);
        chk({tag, ".done_early"}, 64'(bus_b.done), 64'd0);
        @(negedge clk);
        chk({tag, ".done"}, 64'(bus_b.done), 64'd1);
        chk({tag, ".result"}, 64'(bus_b.result), 64'(exp_res));
        chk({tag, ".idx"}, 64'(bus_b.result_idx), 64'(exp_idx));
    endtask

    initial begin
        reset           = 1'b1;
        bus_a.start     = 1'b0;
        bus_a.mode_min  = 1'b0;
        bus_a.is_signed = 1'b0;
        bus_a.operands  = '0;
        bus_b.start     = 1'b0;
        bus_b.mode_min  = 1'b0;
        bus_b.is_signed = 1'b0;
        bus_b.operands  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(bus_a.busy), 64'd0);
        chk("rst.done", 64'(bus_a.done), 64'd0);
        chk("rst.result", 64'(bus_a.result), 64'd0);
        chk("rst.idx", 64'(bus_a.result_idx), 64'd0);
        chk("rst_b.done", 64'(bus_b.done), 64'd0);
        reset = 1'b0;

        // 1: unsigned max with a tie
        job_a(OPS_T1, 1'b0, 1'b0, 32'd9, 2'd1, "t1_umax");

        // 2: signed min, then unsigned min on the same operands
        job_a(OPS_T2, 1'b1, 1'b1, 32'hFFFF_FFF9, 2'd3, "t2_smin");
        job_a(OPS_T2, 1'b1, 1'b0, 32'h0000_0001, 2'd0, "t2_umin");

        // 3: start pulsed mid-scan with changed operands and mode
        @(negedge clk);
        bus_a.operands  = OPS_T1;
        bus_a.mode_min  = 1'b0;
        bus_a.is_signed = 1'b0;
        bus_a.start     = 1'b1;
        @(negedge clk);
        chk("t3.busy0", 64'(bus_a.busy), 64'd1);
        bus_a.operands = OPS_JUNK;
        bus_a.mode_min = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("t3.busy1", 64'(bus_a.busy), 64'd1);
        repeat (2) begin
            @(negedge clk);
            chk("t3.busy", 64'(bus_a.busy), 64'd1);
        end
        @(negedge clk);
        chk("t3.done", 64'(bus_a.done), 64'd1);
        chk("t3.result", 64'(bus_a.result), 64'd9);
        chk("t3.idx", 64'(bus_a.result_idx), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("t3.done_hold", 64'(bus_a.done), 64'd1);
            chk("t3.no_rerun", 64'(bus_a.busy), 64'd0);
        end

        // 4: reset during the second scan cycle, then a clean job
        @(negedge clk);
        bus_a.operands  = OPS_T1;
        bus_a.mode_min  = 1'b0;
        bus_a.is_signed = 1'b0;
        bus_a.start     = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("t4.busy0", 64'(bus_a.busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t4.rst_busy", 64'(bus_a.busy), 64'd0);
        chk("t4.rst_done", 64'(bus_a.done), 64'd0);
        chk("t4.rst_result", 64'(bus_a.result), 64'd0);
        chk("t4.rst_idx", 64'(bus_a.result_idx), 64'd0);
        reset = 1'b0;
        job_a(OPS_T2, 1'b0, 1'b1, 32'h7FFF_FFFF, 2'd2, "t4_smax");

        // 5: start held high, two back-to-back jobs
        @(negedge clk);
        bus_a.operands  = OPS_T1;
        bus_a.mode_min  = 1'b0;
        bus_a.is_signed = 1'b0;
        bus_a.start     = 1'b1;
        @(negedge clk);
        chk("t5.j1_busy0", 64'(bus_a.busy), 64'd1);
        bus_a.operands  = OPS_T2;
        bus_a.is_signed = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5.j1_busy", 64'(bus_a.busy), 64'd1);
        end
        @(negedge clk);
        chk("t5.j1_done", 64'(bus_a.done), 64'd1);
        chk("t5.j1_result", 64'(bus_a.result), 64'd9);
        chk("t5.j1_idx", 64'(bus_a.result_idx), 64'd1);
        @(negedge clk);
        chk("t5.j2_accept_done", 64'(bus_a.done), 64'd0);
        chk("t5.j2_busy0", 64'(bus_a.busy), 64'd1);
        chk("t5.j2_result_hold", 64'(bus_a.result), 64'd9);
        repeat (3) begin
            @(negedge clk);
            chk("t5.j2_busy", 64'(bus_a.busy), 64'd1);
        end
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("t5.j2_done", 64'(bus_a.done), 64'd1);
        chk("t5.j2_result", 64'(bus_a.result), 64'h7FFF_FFFF);
        chk("t5.j2_idx", 64'(bus_a.result_idx), 64'd2);

        // 6: N=2, 8-bit, max, unsigned then signed
        job_b(OPS_T6, 1'b0, 8'h80, 1'b0, "t6_umax");
        job_b(OPS_T6, 1'b1, 8'h7F, 1'b1, "t6_smax");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
